// File: rtl/pci_uart_tx_sequencer.sv
// Byte sequencer between the PCI write path and the UART shift register.
// Optional start timeout is built only when UART_SEQ_TIMEOUT_EN is defined.
module pci_uart_tx_sequencer #(
  parameter int DEPTH          = 8,
  parameter int AW             = 3,
  parameter int WL_W           = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      pci_state,
  input  logic            pci_wr_valid,
  input  logic [7:0]      pci_wr_data,
  output logic            pci_wr_ready,
  input  logic [WL_W-1:0] sr_workload,
  output logic            sr_load,
  output logic [7:0]      sr_data,
  output logic            busy,
  output logic [AW:0]     fifo_count,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic          sr_load_q, sr_load_d;
  logic [7:0]    sr_data_q, sr_data_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          push_s, pop_s;

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign pci_wr_ready = !rst && (count_q != FULL_CNT);
  assign push_s       = pci_wr_valid && pci_wr_ready;
  // The head byte is consumed during the single LOAD cycle.
  assign pop_s        = (state_q == ST_LOAD);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Load/track sequence with registered strobes.
  always_comb begin
    state_d       = state_q;
    sr_load_d     = 1'b0;
    sr_data_d     = sr_data_q;
    timeout_err_d = 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && (pci_state == 3'd0) && (sr_workload == '0)) begin
          state_d   = ST_LOAD;
          sr_load_d = 1'b1;
          sr_data_d = mem_q[rd_ptr_q];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_START;
`ifdef UART_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT_START: begin
        if (sr_workload != '0) begin
          state_d = ST_WAIT_DONE;
        end else begin
`ifdef UART_SEQ_TIMEOUT_EN
          // A start seen on the limit edge takes priority over the timeout.
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`else
          state_d = ST_WAIT_START;
`endif
        end
      end
      ST_WAIT_DONE: begin
        if (sr_workload == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sr_load_q     <= 1'b0;
      sr_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sr_load_q     <= sr_load_d;
      sr_data_q     <= sr_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
`ifdef UART_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= pci_wr_data;
    end
  end

  assign sr_load     = sr_load_q;
  assign sr_data     = sr_data_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pci_uart_tx_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pci_uart_tx_sequencer;

`ifdef UART_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pci_state;
  logic       pci_wr_valid;
  logic [7:0] pci_wr_data;
  logic       pci_wr_ready;
  logic [5:0] sr_workload;
  logic       sr_load;
  logic [7:0] sr_data;
  logic       busy;
  logic [3:0] fifo_count;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered bytes plus a description of the transfer in progress.
  logic [7:0] mq[$];
  bit         m_active, m_loading, m_started, m_load, m_err;
  logic [7:0] m_data;
  int         m_tmo;
  logic [7:0] seen[$];

  pci_uart_tx_sequencer dut (
    .clk(clk), .rst(rst), .pci_state(pci_state), .pci_wr_valid(pci_wr_valid),
    .pci_wr_data(pci_wr_data), .pci_wr_ready(pci_wr_ready), .sr_workload(sr_workload),
    .sr_load(sr_load), .sr_data(sr_data), .busy(busy), .fifo_count(fifo_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge, clock the DUT, then compare every output.
  task automatic step();
    bit push;
    push = pci_wr_valid && !rst && (mq.size() != 8);
    if (rst) begin
      mq.delete();
      m_active = 0; m_loading = 0; m_started = 0; m_load = 0; m_err = 0;
      m_data = 8'h00; m_tmo = 0;
    end else begin
      m_load = 0; m_err = 0;
      if (!m_active) begin
        if (mq.size() != 0 && pci_state == 3'd0 && sr_workload == 6'd0) begin
          m_active = 1; m_loading = 1; m_load = 1; m_data = mq[0];
        end
      end else if (m_loading) begin
        m_loading = 0; m_started = 0; m_tmo = 0;
        void'(mq.pop_front());
      end else if (!m_started) begin
        if (sr_workload != 6'd0) m_started = 1;
        else if (TMO_EN && m_tmo == TMO - 1) begin m_active = 0; m_err = 1; end
        else m_tmo++;
      end else if (sr_workload == 6'd0) begin
        m_active = 0;
      end
      if (push) mq.push_back(pci_wr_data);
    end
    @(posedge clk);
    #1;
    if (sr_load === 1'b1) seen.push_back(sr_data);
    chk("sr_load", 32'(sr_load), 32'(m_load));
    chk("sr_data", 32'(sr_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_active));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    chk("pci_wr_ready", 32'(pci_wr_ready), 32'(!rst && mq.size() != 8));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    pci_wr_valid = 1'b1; pci_wr_data = b;
    step();
    pci_wr_valid = 1'b0;
  endtask

  initial begin
    int sched, wl_cnt;
    rst = 1'b1; pci_state = 3'd0; pci_wr_valid = 1'b0; pci_wr_data = 8'h00; sr_workload = 6'd0;

    // 1: reset then a single byte
    pci_wr_valid = 1'b1; pci_wr_data = 8'h11;
    steps(3);
    chk("ready_in_reset", 32'(pci_wr_ready), 32'd0);
    rst = 1'b0; pci_wr_valid = 1'b0;
    push_byte(8'hA5);
    chk("no_load_first_edge", 32'(sr_load), 32'd0);
    step();
    chk("latency_load", 32'(sr_load), 32'd1);
    chk("latency_data", 32'(sr_data), 32'hA5);
    steps(2);
    sr_workload = 6'd10; steps(3);
    sr_workload = 6'd0;  steps(2);
    chk("busy_after_drain", 32'(busy), 32'd0);

    // 2: fill to full while the shift register is occupied, then drain in order
    sr_workload = 6'd5;
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_ready", 32'(pci_wr_ready), 32'd0);
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      sr_workload = 6'd0; steps(2);
      sr_workload = 6'd3; step();
      sr_workload = 6'd0; step();
    end
    chk("drain_len", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("drain_order", 32'(seen[i]), 32'(i + 1));

    // 4: load coincides with a push while full
    sr_workload = 6'd5;
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
    sr_workload = 6'd0; pci_wr_valid = 1'b1; pci_wr_data = 8'hEE;
    steps(2);
    pci_wr_valid = 1'b0;
    chk("push_at_full_pop", 32'(fifo_count), 32'd7);

    // 5: reset while a transfer is in WAIT_DONE with bytes queued
    sr_workload = 6'd3; steps(2);
    rst = 1'b1; step();
    rst = 1'b0; sr_workload = 6'd0;
    chk("rst_mid_count", 32'(fifo_count), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    seen.delete();
    steps(5);
    chk("rst_mid_noload", 32'(seen.size()), 32'd0);

    // 3: PCI state gating
    pci_state = 3'd3;
    push_byte(8'h3C);
    seen.delete();
    steps(10);
    chk("gated_noload", 32'(seen.size()), 32'd0);
    pci_state = 3'd0; steps(2);
    chk("ungated_load", 32'(seen.size()), 32'd1);
    steps(1);
    sr_workload = 6'd4; step();
    sr_workload = 6'd0; step();

    // 6: start timeout (or indefinite wait when the feature is absent)
    push_byte(8'h77);
    steps(3);
    steps(TMO + 3);
    chk("timeout_busy", 32'(busy), TMO_EN ? 32'd0 : 32'd1);
    sr_workload = 6'd2; step();
    sr_workload = 6'd0; steps(2);

    // Random traffic with an emulated shift register reacting to loads
    sched = -1; wl_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (sched >= 0) begin
        if (sched == 0) begin wl_cnt = int'($urandom_range(1, 9)); sched = -1; end
        else sched--;
      end else if (wl_cnt > 0) begin
        wl_cnt--;
      end
      sr_workload  = 6'(wl_cnt);
      pci_wr_valid = ($urandom_range(0, 2) != 0);
      pci_wr_data  = 8'($urandom);
      pci_state    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      rst          = ($urandom_range(0, 149) == 0);
      step();
      if (rst) begin sched = -1; wl_cnt = 0; end
      else if (m_load) sched = int'($urandom_range(0, 3));
    end
    rst = 1'b0; pci_wr_valid = 1'b0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
